// File: rtl/people_top_control.sv
// people_top_control
//   Player-sprite movement controller for stage 5. Held direction keys move a
//   40x40 sprite by STEP pixels on every movement tick (one per TICK_CYCLES
//   clocks). The sprite stops at the play-field walls, freezes when either
//   ghost reports a hit, and raises a sticky arrive flag when it reaches the
//   goal box.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   stage_state[2:0]    stage FSM state; the block runs only in state 5
//   key_up/down/left/right  debounced level inputs, priority UP>DOWN>LEFT>RIGHT
//   fail1, fail2        ghost collision flags, freeze motion while high
//   people_up[9:0]      sprite top row
//   people_left[9:0]    sprite left column
//   dir[1:0]            facing: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN
//   frame               walk frame, toggles on every tick that moves the sprite
//   arrive              sticky goal-reached flag
module people_top_control #(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int STEP        = 4,
  parameter int START_UP    = 400,
  parameter int START_LEFT  = 40,
  parameter int MIN_UP      = 40,
  parameter int MAX_UP      = 440,
  parameter int MIN_LEFT    = 0,
  parameter int MAX_LEFT    = 600,
  parameter int GOAL_LEFT   = 560,
  parameter int GOAL_UP     = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] stage_state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       fail1,
  input  logic       fail2,
  output logic [9:0] people_up,
  output logic [9:0] people_left,
  output logic [1:0] dir,
  output logic       frame,
  output logic       arrive
);

  localparam logic [1:0]  D_LEFT  = 2'd0;
  localparam logic [1:0]  D_RIGHT = 2'd1;
  localparam logic [1:0]  D_UP    = 2'd2;
  localparam logic [1:0]  D_DOWN  = 2'd3;
  localparam logic [23:0] TICK_LAST = 24'(TICK_CYCLES - 1);

  // 11-bit working copies so "+STEP" can never wrap before the compare.
  localparam logic [10:0] STEP_W      = 11'(STEP);
  localparam logic [10:0] MIN_UP_W    = 11'(MIN_UP);
  localparam logic [10:0] MAX_UP_W    = 11'(MAX_UP);
  localparam logic [10:0] MIN_LEFT_W  = 11'(MIN_LEFT);
  localparam logic [10:0] MAX_LEFT_W  = 11'(MAX_LEFT);

  logic        stage_on;
  logic        active;
  logic        tick;
  logic [23:0] cnt;
  logic        goal;

  logic        key_any;
  logic [1:0]  key_dir;
  logic [10:0] up_w, left_w;
  logic [10:0] nxt_up, nxt_left;
  logic        moved;

  assign stage_on = (stage_state == 3'd5);
  assign active   = stage_on & ~fail1 & ~fail2 & ~arrive;
  assign tick     = active & (cnt == TICK_LAST);
  assign goal     = (people_left >= 10'(GOAL_LEFT)) & (people_up <= 10'(GOAL_UP));

  assign up_w   = {1'b0, people_up};
  assign left_w = {1'b0, people_left};

  // Winning key and the clamped candidate position for it.
  always_comb begin
    key_any  = 1'b1;
    key_dir  = D_RIGHT;
    nxt_up   = up_w;
    nxt_left = left_w;
    if (key_up) begin
      key_dir = D_UP;
      nxt_up  = (up_w < MIN_UP_W + STEP_W) ? MIN_UP_W : up_w - STEP_W;
    end else if (key_down) begin
      key_dir = D_DOWN;
      nxt_up  = (up_w + STEP_W > MAX_UP_W) ? MAX_UP_W : up_w + STEP_W;
    end else if (key_left) begin
      key_dir  = D_LEFT;
      nxt_left = (left_w < MIN_LEFT_W + STEP_W) ? MIN_LEFT_W : left_w - STEP_W;
    end else if (key_right) begin
      key_dir  = D_RIGHT;
      nxt_left = (left_w + STEP_W > MAX_LEFT_W) ? MAX_LEFT_W : left_w + STEP_W;
    end else begin
      key_any = 1'b0;
    end
    moved = (nxt_up != up_w) | (nxt_left != left_w);
  end

  // Movement tick divider: pauses (keeps its count) on fail/arrive,
  // clears only when the stage is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (!stage_on)   cnt <= '0;
    else if (active)      cnt <= (cnt == TICK_LAST) ? '0 : cnt + 24'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      people_up   <= 10'(START_UP);
      people_left <= 10'(START_LEFT);
      dir         <= D_RIGHT;
      frame       <= 1'b0;
    end else if (!stage_on) begin
      people_up   <= 10'(START_UP);
      people_left <= 10'(START_LEFT);
      dir         <= D_RIGHT;
      frame       <= 1'b0;
    end else if (tick && key_any) begin
      dir         <= key_dir;
      people_up   <= nxt_up[9:0];
      people_left <= nxt_left[9:0];
      if (moved) frame <= ~frame;
    end
  end

  // A hit in the same cycle as the goal condition keeps arrive low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           arrive <= 1'b0;
    else if (!stage_on)                arrive <= 1'b0;
    else if (goal && !fail1 && !fail2) arrive <= 1'b1;
  end

endmodule
